// File: rtl/burst_src_fifo.sv
// FWFT source FIFO feeding a valid/ready burst slave, with burst-boundary tracking.
// Optional stall counter enabled by defining BURST_SRC_STALL_CNT_EN.
module burst_src_fifo #(
    parameter int DEPTH     = 8,
    parameter int BURST_LEN = 10,
    parameter int DW        = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [DW-1:0]              in_data,
    output logic                       in_ready,
    output logic                       valid,
    output logic [DW-1:0]              data,
    input  logic                       ready,
    output logic [3:0]                 beat_cnt,
    output logic                       burst_done,
    output logic [$clog2(DEPTH):0]     level,
    output logic [15:0]                stall_cnt
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;
    localparam logic [LVL_W-1:0] FULL = LVL_W'(DEPTH);
    localparam logic [3:0]       LAST = 4'(BURST_LEN - 1);

    logic [DW-1:0]    r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [LVL_W-1:0] r_level;
    logic [3:0]       r_beat_cnt;
    logic             r_burst_done;

    logic w_push;
    logic w_pop;

    // Flags come only from the registered level, so ready/in_valid never loop back.
    assign in_ready = (r_level != FULL);
    assign valid    = (r_level != '0);
    assign data     = valid ? r_mem[r_rd_ptr] : '0;

    assign w_push = in_valid && in_ready;
    assign w_pop  = valid && ready;

    assign level      = r_level;
    assign beat_cnt   = r_beat_cnt;
    assign burst_done = r_burst_done;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_level      <= '0;
            r_beat_cnt   <= '0;
            r_burst_done <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
            // Pulse lands the cycle after the final beat of a burst.
            r_burst_done <= 1'b0;
            if (w_pop) begin
                if (r_beat_cnt == LAST) begin
                    r_beat_cnt   <= '0;
                    r_burst_done <= 1'b1;
                end else begin
                    r_beat_cnt <= r_beat_cnt + 4'd1;
                end
            end
        end
    end

`ifdef BURST_SRC_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (valid && !ready && r_stall_cnt != 16'hFFFF) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_burst_src_fifo.sv
// Bench for burst_src_fifo: scoreboard monitor on the falling edge plus scenario tasks.
module tb_burst_src_fifo;

    localparam int DEPTH     = 8;
    localparam int BURST_LEN = 10;
    localparam int DW        = 4;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          valid;
    logic [DW-1:0] data;
    logic          ready;
    logic [3:0]    beat_cnt;
    logic          burst_done;
    logic [3:0]    level;
    logic [15:0]   stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    burst_src_fifo #(.DEPTH(DEPTH), .BURST_LEN(BURST_LEN), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .valid(valid), .data(data), .ready(ready),
        .beat_cnt(beat_cnt), .burst_done(burst_done),
        .level(level), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: inputs are stable at the falling edge, so what is seen here is
    // exactly what the next rising edge will act on.
    logic [DW-1:0] q[$];
    logic          mon_en = 1'b0;
    int            m_beat = 0;
    logic          m_done = 1'b0;
    logic [15:0]   m_stall = 16'h0;

    always @(negedge clk) begin
        if (mon_en) begin
            n_checks++;
            if (level !== 4'(q.size()) || valid !== (q.size() != 0) ||
                in_ready !== (q.size() != DEPTH)) begin
                n_fail++;
                $display("FAIL mon_level: level=%0d valid=%b in_ready=%b want level=%0d", level, valid, in_ready, q.size());
            end
            n_checks++;
            if (beat_cnt !== 4'(m_beat) || burst_done !== m_done) begin
                n_fail++;
                $display("FAIL mon_burst: beat_cnt=%0d burst_done=%b want %0d %b", beat_cnt, burst_done, m_beat, m_done);
            end
            n_checks++;
            if (stall_cnt !== m_stall) begin
                n_fail++;
                $display("FAIL mon_stall: stall_cnt=%0d want %0d", stall_cnt, m_stall);
            end
            if (q.size() == 0) begin
                n_checks++;
                if (data !== '0) begin
                    n_fail++;
                    $display("FAIL mon_empty_data: data=%0h want 0", data);
                end
            end
        end
        if (rst) begin
            q.delete();
            m_beat  = 0;
            m_done  = 1'b0;
            m_stall = 16'h0;
            mon_en  = 1'b1;
        end else if (mon_en) begin
`ifdef BURST_SRC_STALL_CNT_EN
            if (q.size() != 0 && !ready && m_stall != 16'hFFFF) m_stall++;
`endif
            m_done = 1'b0;
            if (q.size() != 0 && ready) begin
                n_checks++;
                if (data !== q[0]) begin
                    n_fail++;
                    $display("FAIL mon_pop_data: data=%0h want %0h", data, q[0]);
                end
                void'(q.pop_front());
                if (m_beat == BURST_LEN - 1) begin
                    m_beat = 0;
                    m_done = 1'b1;
                end else begin
                    m_beat++;
                end
            end
            if (in_valid && in_ready) q.push_back(in_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1; in_valid = 1'b0; ready = 1'b0;
        repeat (cycles) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if (valid !== 1'b0 || in_ready !== 1'b1 || level !== 4'd0 || beat_cnt !== 4'd0 ||
            burst_done !== 1'b0 || data !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b in_ready=%b level=%0d beat=%0d done=%b data=%0h want 0 1 0 0 0 0",
                     valid, in_ready, level, beat_cnt, burst_done, data);
        end
    endtask

    task automatic test_fill();
        ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = 4'(i);
            tick();
            n_checks++;
            if (data !== 4'h1) begin
                n_fail++;
                $display("FAIL fill_head: data=%0h want 1", data);
            end
        end
        n_checks++;
        if (level !== 4'd8 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_full: level=%0d in_ready=%b want 8 0", level, in_ready);
        end
        in_data = 4'h9;
        tick();
        n_checks++;
        if (level !== 4'd8 || data !== 4'h1) begin
            n_fail++;
            $display("FAIL fill_ninth: level=%0d data=%0h want 8 1", level, data);
        end
        in_valid = 1'b0; ready = 1'b1;
        repeat (8) tick();
        ready = 1'b0;
    endtask

    task automatic test_burst_drain();
        int pulses = 0;
        int pulse_at = -1;
        int last_pop = -1;
        do_reset(1);
        ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            in_valid = (c < 10);
            in_data  = 4'(c);
            if (valid && ready && data == 4'h9) last_pop = c;
            tick();
            if (burst_done) begin
                pulses++;
                pulse_at = c;
            end
        end
        n_checks++;
        if (pulses != 1 || pulse_at != last_pop || last_pop < 0) begin
            n_fail++;
            $display("FAIL burst_pulse: pulses=%0d at=%0d want 1 at %0d", pulses, pulse_at, last_pop);
        end
        n_checks++;
        if (beat_cnt !== 4'd0 || level !== 4'd0) begin
            n_fail++;
            $display("FAIL burst_end: beat=%0d level=%0d want 0 0", beat_cnt, level);
        end
        ready = 1'b0;
    endtask

    task automatic test_stall();
        int sent = 0, pops = 0, stalls = 0, cyc = 0;
        logic [DW-1:0] held = '0;
        do_reset(1);
        while (pops < 15 && cyc < 100) begin
            in_valid = (sent < 15);
            in_data  = 4'(sent);
            if (pops < 10) ready = 1'b1;
            else if (stalls < 7) begin
                ready = 1'b0;
                if (stalls == 0) held = data;
                n_checks++;
                if (valid !== 1'b1 || data !== held) begin
                    n_fail++;
                    $display("FAIL stall_hold: valid=%b data=%0h want 1 %0h", valid, data, held);
                end
                stalls++;
            end else ready = 1'b1;
            if (in_valid && in_ready) sent++;
            if (valid && ready) pops++;
            tick();
            cyc++;
        end
        in_valid = 1'b0; ready = 1'b0;
        n_checks++;
        if (held !== 4'hA || pops != 15) begin
            n_fail++;
            $display("FAIL stall_word: held=%0h pops=%0d want a 15", held, pops);
        end
        n_checks++;
`ifdef BURST_SRC_STALL_CNT_EN
        if (stall_cnt !== 16'd7) begin
            n_fail++;
            $display("FAIL stall_cnt: got %0d want 7", stall_cnt);
        end
`else
        if (stall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL stall_cnt: got %0d want 0", stall_cnt);
        end
`endif
    endtask

    task automatic test_simul();
        do_reset(1);
        ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 4'(i + 3);
            tick();
        end
        ready = 1'b1; in_data = 4'hF;
        tick();
        n_checks++;
        if (level !== 4'd7 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_full: level=%0d in_ready=%b want 7 1", level, in_ready);
        end
        tick();
        n_checks++;
        if (level !== 4'd7) begin
            n_fail++;
            $display("FAIL simul_l7: level=%0d want 7", level);
        end
        in_valid = 1'b0;
        repeat (7) tick();
        in_valid = 1'b1; ready = 1'b0; in_data = 4'h5;
        tick();
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 4'(i + 6);
            tick();
            n_checks++;
            if (level !== 4'd1) begin
                n_fail++;
                $display("FAIL simul_l1: level=%0d want 1", level);
            end
        end
        for (int i = 0; i < 20; ) begin
            in_valid = ($urandom_range(3) != 0);
            in_data  = 4'($urandom);
            ready    = ($urandom_range(1) != 0);
            if (in_valid && in_ready) i++;
            tick();
        end
        in_valid = 1'b0; ready = 1'b1;
        repeat (DEPTH + 1) tick();
        n_checks++;
        if (level !== 4'd0) begin
            n_fail++;
            $display("FAIL wrap_drain: level=%0d want 0", level);
        end
        ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        do_reset(1);
        ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_data = 4'(i);
            tick();
        end
        in_valid = 1'b0; ready = 1'b1;
        repeat (4) tick();
        ready = 1'b0;
        n_checks++;
        if (level !== 4'd3 || beat_cnt !== 4'd4) begin
            n_fail++;
            $display("FAIL mid_pre: level=%0d beat=%0d want 3 4", level, beat_cnt);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (valid !== 1'b0 || level !== 4'd0 || beat_cnt !== 4'd0 || burst_done !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: valid=%b level=%0d beat=%0d done=%b want 0 0 0 0", valid, level, beat_cnt, burst_done);
        end
        ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            in_valid = (c < 10);
            in_data  = 4'(9 - c);
            tick();
            if (burst_done) pulses++;
        end
        n_checks++;
        if (pulses != 1 || beat_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL mid_fresh: pulses=%0d beat=%0d want 1 0", pulses, beat_cnt);
        end
        in_valid = 1'b0; ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_burst_drain();
        test_stall();
        test_simul();
        test_reset_mid();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
